// File: rtl/u109_pkg.sv
`default_nettype none
// ============================================================================
// Module      : u109_pkg
// Description : Shared constants for the U109 PCI reset / interrupt block.
// Revision    : 1.0 - initial release
// ============================================================================
package u109_pkg;

  localparam int c_CNT_W           = 16;
  localparam int c_RST_ASSERT_DEF  = 40000;
  localparam int c_RST_RECOVER_DEF = 4000;

  typedef logic [c_CNT_W-1:0] cnt_t;
  typedef logic [1:0]         state_t;

  localparam logic [1:0] c_ST_POR_HOLD = 2'd0;
  localparam logic [1:0] c_ST_RECOVER  = 2'd1;
  localparam logic [1:0] c_ST_IDLE     = 2'd2;
  localparam logic [1:0] c_ST_SW_HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/u109_int_sync.sv
`default_nettype none
// ============================================================================
// Module      : u109_int_sync
// Description : 4-wide INTx synchroniser; optional 3-sample glitch filter
//               enabled by U109_INT_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module u109_int_sync
  import u109_pkg::*;
(
  input  logic       CLK40,
  input  logic       RESETn,
  input  logic [3:0] INTn,
  output logic [3:0] int_syncn
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= INTn;
      r_sync <= r_meta;
    end
  end

`ifdef U109_INT_FILTER_EN
  logic [3:0] r_hist0;
  logic [3:0] r_hist1;
  logic [3:0] r_filt;
  logic [3:0] w_agree;
  logic [3:0] w_filt;

  // The current sample and the two before it must match for the output to move.
  assign w_agree = ~(r_sync ^ r_hist0) & ~(r_sync ^ r_hist1);
  assign w_filt  = (w_agree & r_sync) | (~w_agree & r_filt);

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      r_hist0 <= 4'hF;
      r_hist1 <= 4'hF;
      r_filt  <= 4'hF;
    end else begin
      r_hist0 <= r_sync;
      r_hist1 <= r_hist0;
      r_filt  <= w_filt;
    end
  end

  assign int_syncn = w_filt;
`else
  assign int_syncn = r_sync;
`endif

endmodule
`default_nettype wire

// File: rtl/u109_pci_reset_int.sv
`default_nettype none
// ============================================================================
// Module      : u109_pci_reset_int
// Description : PCI_RSTn power-on / software reset sequencer and INTx
//               concentrator. Optional filter macro: U109_INT_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module u109_pci_reset_int
  import u109_pkg::*;
#(
  parameter int RST_ASSERT_CYCLES  = c_RST_ASSERT_DEF,
  parameter int RST_RECOVER_CYCLES = c_RST_RECOVER_DEF
) (
  input  logic       CLK40,
  input  logic       RESETn,
  input  logic       REG_PCI_RESET,
  input  logic       INT_ENn,
  input  logic [3:0] INTn,
  output logic       PCI_RSTn,
  output logic       PCI_RESET_BUSY,
  output logic       INT_STATUSn,
  output logic       INT2n
);

  localparam cnt_t c_ASSERT_LAST  = cnt_t'(RST_ASSERT_CYCLES - 1);
  localparam cnt_t c_RECOVER_LAST = cnt_t'(RST_RECOVER_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  cnt_t       r_cnt;
  cnt_t       w_cnt_nxt;
  logic       r_sw_req;
  logic [3:0] w_int_syncn;

  u109_int_sync u_int_sync (
    .CLK40     (CLK40),
    .RESETn    (RESETn),
    .INTn      (INTn),
    .int_syncn (w_int_syncn)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + cnt_t'(1);
    case (r_state)
      c_ST_POR_HOLD: begin
        if (r_cnt == c_ASSERT_LAST) begin
          w_state_nxt = c_ST_RECOVER;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_RECOVER: begin
        if (r_sw_req) begin
          w_state_nxt = c_ST_SW_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_RECOVER_LAST) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_sw_req) begin
          w_state_nxt = c_ST_SW_HOLD;
        end
      end
      c_ST_SW_HOLD: begin
        // Saturate so an early clear cannot shorten the pulse.
        if (r_cnt == c_ASSERT_LAST) begin
          w_cnt_nxt = r_cnt;
          if (!r_sw_req) begin
            w_state_nxt = c_ST_RECOVER;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = c_ST_POR_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      r_state        <= c_ST_POR_HOLD;
      r_cnt          <= '0;
      r_sw_req       <= 1'b0;
      PCI_RSTn       <= 1'b0;
      PCI_RESET_BUSY <= 1'b1;
      INT_STATUSn    <= 1'b1;
      INT2n          <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_sw_req       <= REG_PCI_RESET;
      PCI_RSTn       <= (w_state_nxt == c_ST_RECOVER) || (w_state_nxt == c_ST_IDLE);
      PCI_RESET_BUSY <= (w_state_nxt != c_ST_IDLE);
      INT_STATUSn    <= &w_int_syncn;
      INT2n          <= INT_STATUSn | INT_ENn | PCI_RESET_BUSY;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_u109_pci_reset_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_u109_pci_reset_int
// Description : Directed self-checking bench for u109_pci_reset_int
//               (RST_ASSERT_CYCLES = 8, RST_RECOVER_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u109_pci_reset_int;

  logic       CLK40;
  logic       RESETn;
  logic       REG_PCI_RESET;
  logic       INT_ENn;
  logic [3:0] INTn;
  logic       PCI_RSTn;
  logic       PCI_RESET_BUSY;
  logic       INT_STATUSn;
  logic       INT2n;

  int total;
  int bad;

  u109_pci_reset_int #(
    .RST_ASSERT_CYCLES  (8),
    .RST_RECOVER_CYCLES (4)
  ) dut (
    .CLK40          (CLK40),
    .RESETn         (RESETn),
    .REG_PCI_RESET  (REG_PCI_RESET),
    .INT_ENn        (INT_ENn),
    .INTn           (INTn),
    .PCI_RSTn       (PCI_RSTn),
    .PCI_RESET_BUSY (PCI_RESET_BUSY),
    .INT_STATUSn    (INT_STATUSn),
    .INT2n          (INT2n)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++; if (PCI_RSTn !== 1'b0) begin bad++; $display("FAIL rst_pci_rstn got=%b want=0", PCI_RSTn); end
    total++; if (PCI_RESET_BUSY !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", PCI_RESET_BUSY); end
    total++; if (INT_STATUSn !== 1'b1) begin bad++; $display("FAIL rst_status got=%b want=1", INT_STATUSn); end
    total++; if (INT2n !== 1'b1) begin bad++; $display("FAIL rst_int2n got=%b want=1", INT2n); end
  endtask

  task automatic test_por();
    logic exp_rst, exp_busy;
    RESETn = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_rst  = (k >= 8);
      exp_busy = (k < 12);
      total++; if (PCI_RSTn !== exp_rst) begin bad++; $display("FAIL por_rstn k=%0d got=%b want=%b", k, PCI_RSTn, exp_rst); end
      total++; if (PCI_RESET_BUSY !== exp_busy) begin bad++; $display("FAIL por_busy k=%0d got=%b want=%b", k, PCI_RESET_BUSY, exp_busy); end
      total++; if (INT2n !== 1'b1) begin bad++; $display("FAIL por_int2n k=%0d got=%b want=1", k, INT2n); end
    end
  endtask

  task automatic test_sw_short();
    logic exp_rst, exp_busy;
    REG_PCI_RESET = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      REG_PCI_RESET = 1'b0;
      exp_rst  = !(k >= 2 && k < 10);
      exp_busy = (k >= 2 && k < 14);
      total++; if (PCI_RSTn !== exp_rst) begin bad++; $display("FAIL sw_short_rstn k=%0d got=%b want=%b", k, PCI_RSTn, exp_rst); end
      total++; if (PCI_RESET_BUSY !== exp_busy) begin bad++; $display("FAIL sw_short_busy k=%0d got=%b want=%b", k, PCI_RESET_BUSY, exp_busy); end
    end
  endtask

  // Held for 20 samples, then re-requested once while recovering.
  task automatic test_sw_held();
    logic exp_rst, exp_busy;
    REG_PCI_RESET = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      tick();
      REG_PCI_RESET = (k < 20) || (k == 23);
      exp_rst  = !((k >= 2 && k < 22) || (k >= 25 && k < 33));
      exp_busy = (k >= 2 && k < 37);
      total++; if (PCI_RSTn !== exp_rst) begin bad++; $display("FAIL sw_held_rstn k=%0d got=%b want=%b", k, PCI_RSTn, exp_rst); end
      total++; if (PCI_RESET_BUSY !== exp_busy) begin bad++; $display("FAIL sw_held_busy k=%0d got=%b want=%b", k, PCI_RESET_BUSY, exp_busy); end
    end
  endtask

  task automatic test_interrupt();
    logic exp_st, exp_i2;
    INT_ENn = 1'b0;
    INTn    = 4'b1101;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_st = !(k >= 3);
      exp_i2 = !(k >= 4);
      total++; if (INT_STATUSn !== exp_st) begin bad++; $display("FAIL int_status k=%0d got=%b want=%b", k, INT_STATUSn, exp_st); end
      total++; if (INT2n !== exp_i2) begin bad++; $display("FAIL int_int2n k=%0d got=%b want=%b", k, INT2n, exp_i2); end
    end
    INT_ENn = 1'b1;
    tick();
    total++; if (INT2n !== 1'b1) begin bad++; $display("FAIL int_masked got=%b want=1", INT2n); end
    total++; if (INT_STATUSn !== 1'b0) begin bad++; $display("FAIL int_masked_status got=%b want=0", INT_STATUSn); end
    INT_ENn = 1'b0;
    tick();
    total++; if (INT2n !== 1'b0) begin bad++; $display("FAIL int_unmasked got=%b want=0", INT2n); end
    INTn = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_st = (k >= 3);
      total++; if (INT_STATUSn !== exp_st) begin bad++; $display("FAIL int_release k=%0d got=%b want=%b", k, INT_STATUSn, exp_st); end
    end
    tick();
    total++; if (INT2n !== 1'b1) begin bad++; $display("FAIL int_release_int2n got=%b want=1", INT2n); end
  endtask

  task automatic test_reset_mid();
    logic exp_rst, exp_busy;
    INTn = 4'b0111;
    REG_PCI_RESET = 1'b1;
    tick();
    REG_PCI_RESET = 1'b0;
    repeat (6) tick();
    total++; if (INT_STATUSn !== 1'b0) begin bad++; $display("FAIL mid_pre_status got=%b want=0", INT_STATUSn); end
    RESETn = 1'b0;
    #1;
    total++; if (PCI_RSTn !== 1'b0) begin bad++; $display("FAIL mid_rstn got=%b want=0", PCI_RSTn); end
    total++; if (PCI_RESET_BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", PCI_RESET_BUSY); end
    total++; if (INT_STATUSn !== 1'b1) begin bad++; $display("FAIL mid_status got=%b want=1", INT_STATUSn); end
    total++; if (INT2n !== 1'b1) begin bad++; $display("FAIL mid_int2n got=%b want=1", INT2n); end
    INTn = 4'hF;
    repeat (2) tick();
    RESETn = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_rst  = (k >= 8);
      exp_busy = (k < 12);
      total++; if (PCI_RSTn !== exp_rst) begin bad++; $display("FAIL mid_por_rstn k=%0d got=%b want=%b", k, PCI_RSTn, exp_rst); end
      total++; if (PCI_RESET_BUSY !== exp_busy) begin bad++; $display("FAIL mid_por_busy k=%0d got=%b want=%b", k, PCI_RESET_BUSY, exp_busy); end
    end
  endtask

  task automatic test_filter();
    logic exp_st;
    for (int len = 2; len <= 3; len++) begin
      INTn = 4'b1110;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (k == len) INTn = 4'hF;
`ifdef U109_INT_FILTER_EN
        exp_st = (len == 2) ? 1'b1 : !(k >= 5 && k <= 7);
`else
        exp_st = !(k >= 3 && k <= len + 2);
`endif
        total++; if (INT_STATUSn !== exp_st) begin bad++; $display("FAIL filter len=%0d k=%0d got=%b want=%b", len, k, INT_STATUSn, exp_st); end
      end
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    RESETn        = 1'b0;
    REG_PCI_RESET = 1'b0;
    INT_ENn       = 1'b0;
    INTn          = 4'hF;
    test_reset();
    test_por();
    test_sw_short();
    test_sw_held();
    test_interrupt();
    test_reset_mid();
    test_filter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
